// File: rtl/stream_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_if
// Purpose  : Handshake and data bundle for stream_mux (N inputs, one output).
// Revision : 1.0 - initial release
// ============================================================================
interface stream_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) ();
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux
// Purpose  : Registered N-channel stream mux, fixed select or round-robin.
//            Round-robin arbiter is built only with STREAM_MUX_RR_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst,
  stream_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_chan_q,  out_chan_d;

  logic                w_load_en;
  logic                w_rr_mode;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_xfer_data;
  logic [SEL_W-1:0]    w_xfer_chan;
  logic [CHANNELS-1:0] w_fixed_ready;
  logic [CHANNELS-1:0] w_rr_ready;
  logic [CHANNELS-1:0] w_ready;

  assign w_load_en = ~out_valid_q | bus.out_ready;

  // A select value outside 0..CHANNELS-1 simply matches no channel.
  always_comb begin
    w_fixed_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.sel == SEL_W'(i)) w_fixed_ready[i] = w_load_en;
    end
  end

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] last_q, last_d;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  int               w_rr_best;

  // Position of chan in the search order that starts just after last.
  function automatic int rr_dist(input int chan, input int last);
    return (chan - last - 1 + 2 * CHANNELS) % CHANNELS;
  endfunction

  assign w_rr_mode = bus.mode;

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_best  = CHANNELS;
    w_rr_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.in_valid[i] && (rr_dist(i, int'(last_q)) < w_rr_best)) begin
        w_rr_found = 1'b1;
        w_rr_idx   = SEL_W'(i);
        w_rr_best  = rr_dist(i, int'(last_q));
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      w_rr_ready[i] = w_rr_found && (w_rr_idx == SEL_W'(i)) && w_load_en;
    end
  end

  // Pointer moves only on a completed transfer, never on a stalled grant.
  always_comb begin
    last_d = last_q;
    if (w_rr_mode && w_xfer) last_d = w_xfer_chan;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= SEL_W'(CHANNELS - 1);
    else     last_q <= last_d;
  end
`else
  assign w_rr_mode  = 1'b0 & bus.mode;
  assign w_rr_ready = '0;
`endif

  assign w_ready      = rst ? '0 : (w_rr_mode ? w_rr_ready : w_fixed_ready);
  assign bus.in_ready = w_ready;

  always_comb begin
    w_xfer      = 1'b0;
    w_xfer_data = '0;
    w_xfer_chan = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.in_valid[i] && w_ready[i]) begin
        w_xfer      = 1'b1;
        w_xfer_data = bus.in_data[i*WIDTH +: WIDTH];
        w_xfer_chan = SEL_W'(i);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_xfer_data;
      out_chan_d  = w_xfer_chan;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stream_mux
// Purpose  : Self-checking bench for stream_mux (4-channel and 3-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(8), .CHANNELS(4)) bus ();
  stream_mux #(.WIDTH(8), .CHANNELS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  stream_mux_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();
  stream_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // Reference state: the held beat and the round-robin pointer.
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_last;

  logic [3:0] s_rdy;
  logic       s_ov;
  logic [7:0] s_od;
  logic [1:0] s_oc;

  typedef struct {
    bit         r;
    bit         md;
    logic [1:0] s;
    logic [3:0] v;
    logic [31:0] d;
    bit         ordy;
    logic [3:0] e_rdy;
    bit         e_ov;
    logic [7:0] e_od;
    logic [1:0] e_oc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_rr();
    bit rr = 1'b0;
`ifdef STREAM_MUX_RR_EN
    rr = bus.mode;
`endif
    return rr;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r = '0;
    bit le;
    if (rst) return '0;
    le = !m_valid || bus.out_ready;
    if (model_rr()) begin
      for (int k = 1; k <= C; k++) begin
        int c;
        c = (m_last + k) % C;
        if (bus.in_valid[c]) begin
          r[c] = le;
          return r;
        end
      end
    end else if (int'(bus.sel) < C) begin
      r[bus.sel] = le;
    end
    return r;
  endfunction

  task automatic model_edge(input logic [3:0] er);
    logic [3:0] x;
    x = er & bus.in_valid;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_last  = C - 1;
    end else if (x != 4'b0) begin
      for (int i = 0; i < C; i++) begin
        if (x[i]) begin
          m_data = bus.in_data[i*8 +: 8];
          m_chan = i;
        end
      end
      m_valid = 1'b1;
      if (model_rr()) m_last = m_chan;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit md, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input bit ordy);
    rst           = r;
    bus.mode      = md;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic [3:0] er;
    #1;
    er    = model_ready();
    s_rdy = bus.in_ready;
    chk("in_ready", 32'(s_rdy), 32'(er));
    @(posedge clk);
    model_edge(er);
    #1;
    s_ov = bus.out_valid;
    s_od = bus.out_data;
    s_oc = bus.out_chan;
    chk("out_valid", 32'(s_ov), 32'(m_valid));
    chk("out_data", 32'(s_od), 32'(m_data));
    chk("out_chan", 32'(s_oc), 32'(m_chan));
    @(negedge clk);
  endtask

  task automatic step3(input bit r, input bit md, input logic [1:0] s, input logic [2:0] v,
                       input logic [23:0] d, input bit ordy, input logic [2:0] e_rdy,
                       input bit e_ov, input logic [7:0] e_od, input logic [1:0] e_oc);
    rst3           = r;
    bus3.mode      = md;
    bus3.sel       = s;
    bus3.in_valid  = v;
    bus3.in_data   = d;
    bus3.out_ready = ordy;
    #1;
    chk("c3_in_ready", 32'(bus3.in_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk("c3_out_valid", 32'(bus3.out_valid), 32'(e_ov));
    chk("c3_out_data", 32'(bus3.out_data), 32'(e_od));
    chk("c3_out_chan", 32'(bus3.out_chan), 32'(e_oc));
    @(negedge clk);
  endtask

`ifdef STREAM_MUX_RR_EN
  localparam logic [7:0] C3_HOLD_OD = 8'h66;
  localparam logic [1:0] C3_HOLD_OC = 2'd0;
`else
  localparam logic [7:0] C3_HOLD_OD = 8'h55;
  localparam logic [1:0] C3_HOLD_OC = 2'd2;
`endif

  initial begin
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_last  = C - 1;
    drive(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0);
    rst3 = 1'b1;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;

    //          rst mode sel valid  data          ordy  rdy   ov  od     oc
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h00A5_0000, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h003C_0000, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd2};
    tbl[3]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h003C_0000, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h003C_0000, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd2};
    tbl[5]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h003C_0000, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd2};
    tbl[6]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h003C_0000, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd2};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, 4'h4, 32'h003C_0000, 1'b1, 4'h4, 1'b1, 8'h3C, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h003C_0000, 1'b1, 4'h4, 1'b0, 8'h3C, 2'd2};
    tbl[9]  = '{1'b0, 1'b0, 2'd3, 4'h8, 32'h7700_0000, 1'b0, 4'h8, 1'b1, 8'h77, 2'd3};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 4'h1, 32'h0000_0011, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 4'h1, 32'h0000_0022, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 2'd1, 4'h0, 32'h0000_0000, 1'b0, 4'h2, 1'b0, 8'h00, 2'd0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].ordy);
      step();
      chk($sformatf("v%0d_rdy", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_ov", i), 32'(s_ov), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_od", i), 32'(s_od), 32'(tbl[i].e_od));
      chk($sformatf("v%0d_oc", i), 32'(s_oc), 32'(tbl[i].e_oc));
    end

`ifdef STREAM_MUX_RR_EN
    drive(1'b1, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 2'd0, 4'hF, $urandom, 1'b1);
      step();
      chk($sformatf("rr_all_ov%0d", k), 32'(s_ov), 32'd1);
      chk($sformatf("rr_all_chan%0d", k), 32'(s_oc), 32'(k % 4));
    end
    drive(1'b1, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b1, 2'd0, 4'b1010, 32'hDD00_CC00, 1'b1);
    step();
    chk("rr13_rdy_a", 32'(s_rdy), 32'h2);
    chk("rr13_chan_a", 32'(s_oc), 32'd1);
    drive(1'b0, 1'b1, 2'd0, 4'b1010, 32'hDD00_CC00, 1'b0);
    step();
    chk("rr13_rdy_stall", 32'(s_rdy), 32'h0);
    chk("rr13_chan_stall", 32'(s_oc), 32'd1);
    drive(1'b0, 1'b1, 2'd0, 4'b1010, 32'hDD00_CC00, 1'b1);
    step();
    chk("rr13_rdy_b", 32'(s_rdy), 32'h8);
    chk("rr13_chan_b", 32'(s_oc), 32'd3);
    chk("rr13_data_b", 32'(s_od), 32'hDD);
`else
    drive(1'b0, 1'b1, 2'd1, 4'b0011, 32'h0000_4422, 1'b1);
    step();
    chk("norr_rdy", 32'(s_rdy), 32'h2);
    chk("norr_data", 32'(s_od), 32'h44);
    chk("norr_chan", 32'(s_oc), 32'd1);
`endif

    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
            $urandom, ($urandom_range(0, 3) != 0));
      step();
    end

    step3(1'b1, 1'b0, 2'd0, 3'b000, 24'h0, 1'b0, 3'b000, 1'b0, 8'h00, 2'd0);
`ifdef STREAM_MUX_RR_EN
    step3(1'b0, 1'b1, 2'd0, 3'b100, 24'h55_0000, 1'b1, 3'b100, 1'b1, 8'h55, 2'd2);
    step3(1'b0, 1'b1, 2'd0, 3'b001, 24'h00_0066, 1'b1, 3'b001, 1'b1, 8'h66, 2'd0);
`else
    step3(1'b0, 1'b0, 2'd2, 3'b100, 24'h55_0000, 1'b1, 3'b100, 1'b1, 8'h55, 2'd2);
`endif
    step3(1'b0, 1'b0, 2'd3, 3'b111, 24'h12_3456, 1'b1, 3'b000, 1'b0, C3_HOLD_OD, C3_HOLD_OC);
    step3(1'b0, 1'b0, 2'd3, 3'b111, 24'h12_3456, 1'b0, 3'b000, 1'b0, C3_HOLD_OD, C3_HOLD_OC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stream_mux.md
# stream_mux

Parametrised, registered N-channel stream multiplexer, the successor to the single-bit combinational 2:1/4:1 muxes. It selects one of CHANNELS input streams, each WIDTH bits with a valid/ready handshake, and forwards it through a one-entry output register. It sits between ALU operand/result sources and downstream consumers. Selection is either explicit (`sel`) or round-robin arbitration among valid channels.

## Interface
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of input channels, at least 2.
- `SEL_W`, `$clog2(CHANNELS)`: select and channel-index width. Localparam, not overridable.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready. Combinational; at most one bit high.
- `sel`  in  SEL_W  explicit channel select (fixed mode).
- `mode`  in  1  0 = fixed select, 1 = round-robin. Ignored without `STREAM_MUX_RR_EN`.
- `out_data`  out  WIDTH  registered output data.
- `out_chan`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts a beat.

## Operation
- Output register is one entry. `load_en = ~out_valid | out_ready`.
- A transfer on channel i happens when `in_valid[i] & in_ready[i]`. The register then loads `in_data[i]` and sets `out_chan` to i and `out_valid` to 1.
- If `out_valid & out_ready` and no input transfer occurs, `out_valid` clears. `out_data` and `out_chan` hold their values.
- Fixed mode:
  - Chosen channel is `sel`.
  - `in_ready[sel] = load_en`; all other ready bits are 0.
  - If `sel >= CHANNELS`, all ready bits are 0 and nothing loads.
- Round-robin mode:
  - Pointer `last` (SEL_W bits) holds the most recent granted channel.
  - Search order is `last+1, last+2, ...`, wrapping modulo CHANNELS, not modulo 2^SEL_W.
  - The first channel in that order with `in_valid` high is chosen, and `in_ready[chosen] = load_en`.
  - If no channel is valid, all ready bits are 0.
  - `last` updates to the chosen channel only on an actual transfer. A stalled grant does not advance the pointer.
- `in_ready` never depends on the requesting channel's own `in_valid` in fixed mode. In round-robin mode it depends on all `in_valid` bits.
- Changing `mode` or `sel` takes effect in the same cycle, because both are combinational into the choice. A beat already in the output register is unaffected.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `last`=CHANNELS-1, so channel 0 has first round-robin priority.
- During `rst`, `in_ready` is all 0 and no transfers occur. Reset mid-stream discards the held beat; `out_valid` is 0 on the cycle after the reset edge.
- Latency is 1 cycle from input transfer to `out_valid` high.
- Throughput is 1 beat/cycle with `out_ready` held high. Simultaneous drain and load in one cycle is required.
- `out_ready` low with `out_valid` high holds `out_data` and `out_chan` stable and forces all `in_ready` to 0.
- `out_valid`, `out_data` and `out_chan` are register outputs. `in_ready` is combinational from `out_valid`, `out_ready`, `mode`, `sel`, `in_valid` and `last`.

## Configuration
- Macro `STREAM_MUX_RR_EN`.
- Defined: the round-robin arbiter and `last` pointer are built, and `mode` selects between fixed and round-robin.
- Undefined: no arbiter logic and no `last` register. `mode` is ignored and the block always operates in fixed mode. The port list is unchanged.

## Test plan
- Reset, then fixed mode, `sel`=2, `in_valid`=4'b0100, `in_data[2]`=8'hA5, `out_ready`=1 -> `in_ready`=4'b0100. The next cycle shows `out_valid`=1, `out_data`=8'hA5, `out_chan`=2.
- Fixed mode, `out_ready`=0 after one load -> `in_ready`=0. `out_data` holds for 5 cycles. When `out_ready` rises, a new beat loads the same cycle the old one drains.
- Round-robin, all four channels valid continuously, `out_ready`=1 -> `out_chan` sequence is 0,1,2,3,0,1 at one beat/cycle.
- Round-robin, only channels 1 and 3 valid, `out_ready` toggling 1,0,1 -> grants go 1 then 3. The stalled cycle does not advance `last`.
- CHANNELS=3, round-robin, `last`=2, only ch0 valid -> wraps to ch0 without stalling. Fixed mode with `sel`=3 -> `in_ready`=0 and no load.
- Build without `STREAM_MUX_RR_EN`, `mode`=1, `sel`=1 -> behaves as fixed mode on channel 1.
